dpe: RTL and testbench

Data plane engine top level: a 5×5 AXI-Stream packet switch between the CPU port and four Ethernet ports.
- Each ingress packet is routed by its `tuser_dst` address to one egress port, or to all other ports on broadcast.
- Packets are never interleaved on an egress port.
- It sits between the MAC/CPU DMA adapters and the per-port egress logic, and exposes `pause`/`is_idle` for orderly reconfiguration.

---
 rtl/dpe_pkg.sv | 55 +++++
 rtl/dpe_if.sv | 34 +++
 rtl/dpe_skid_buf.sv | 52 +++++
 rtl/dpe.sv | 230 +++++++++++++++++++++++
 tb/tb_dpe.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpe_pkg.sv
// dpe_pkg: widths, port addresses, beat bundle and routing helpers.
// Define DPE_BCAST_EN to build broadcast replication into dpe_route().
package dpe_pkg;

  localparam int DATA_W  = 128;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int N_PORTS = 5;

  typedef logic [2:0] dpe_addr_t;
  typedef logic [N_PORTS-1:0] dpe_mask_t;

  localparam dpe_addr_t DPE_ADDR_CPU   = 3'd0;
  localparam dpe_addr_t DPE_ADDR_ETH_1 = 3'd1;
  localparam dpe_addr_t DPE_ADDR_ETH_2 = 3'd2;
  localparam dpe_addr_t DPE_ADDR_ETH_3 = 3'd3;
  localparam dpe_addr_t DPE_ADDR_ETH_4 = 3'd4;
  localparam dpe_addr_t DPE_ADDR_BCAST = 3'd7;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
    logic              byp_all;
    logic              byp_stage;
    dpe_addr_t         src;
    dpe_addr_t         dst;
  } dpe_beat_t;

  // An empty mask means the packet is dropped.
  function automatic dpe_mask_t dpe_route(
    input dpe_addr_t dst,
    input dpe_addr_t src
  );
    dpe_mask_t m;
    m = '0;
    if (dst <= DPE_ADDR_ETH_4)
      m = dpe_mask_t'(1) << dst;
`ifdef DPE_BCAST_EN
    else if (dst == DPE_ADDR_BCAST)
      m = ~(dpe_mask_t'(1) << src);
`else
    else if (src == DPE_ADDR_BCAST)
      m = '0;
`endif
    return m;
  endfunction

  function automatic dpe_addr_t dpe_inc(
    input dpe_addr_t a,
    input int        k
  );
    return dpe_addr_t'((int'(a) + k) % N_PORTS);
  endfunction

endpackage

// File: rtl/dpe_if.sv
// dpe_if: AXI-Stream port bundle of the dpe switch.
// clk/rst are shared by every port instance.
interface dpe_if
  import dpe_pkg::*;
(
  input logic clk,
  input logic rst
);

  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [KEEP_W-1:0] tkeep;
  logic [DATA_W-1:0] tdata;
  logic              tuser_bypass_all;
  logic              tuser_bypass_stage;
  dpe_addr_t         tuser_src;
  dpe_addr_t         tuser_dst;

  modport master (
    input  clk, rst, tready,
    output tvalid, tlast, tkeep, tdata,
    output tuser_bypass_all, tuser_bypass_stage,
    output tuser_src, tuser_dst
  );

  modport slave (
    input  clk, rst, tvalid, tlast, tkeep, tdata,
    input  tuser_bypass_all, tuser_bypass_stage,
    input  tuser_src, tuser_dst,
    output tready
  );

endinterface

// File: rtl/dpe_skid_buf.sv
// dpe_skid_buf: 2-entry ingress buffer with a registered ready.
// Ready is low in reset and rises on the first edge after release.
module dpe_skid_buf
  import dpe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  dpe_beat_t in_beat,
  output logic      out_valid,
  input  logic      out_ready,
  output dpe_beat_t out_beat
);

  dpe_beat_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic [1:0] cnt_n;
  logic       rdy_q;
  logic       push;
  logic       pop;

  assign push      = in_valid & rdy_q;
  assign pop       = out_valid & out_ready;
  assign out_valid = cnt != 2'd0;
  assign out_beat  = mem[rd_ptr];
  assign in_ready  = rdy_q;
  assign cnt_n     = cnt + 2'(push) - 2'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rdy_q  <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      cnt   <= cnt_n;
      rdy_q <= cnt_n != 2'd2;
      if (push) begin
        mem[wr_ptr] <= in_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: rtl/dpe.sv
// dpe: 5x5 AXI-Stream packet switch, CPU port plus four Ethernet ports.
// Broadcast replication is built only with DPE_BCAST_EN defined.
module dpe
  import dpe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  pause,
  output logic  is_idle,
  dpe_if.slave  from_cpu,
  dpe_if.slave  from_eth_1,
  dpe_if.slave  from_eth_2,
  dpe_if.slave  from_eth_3,
  dpe_if.slave  from_eth_4,
  dpe_if.master to_cpu,
  dpe_if.master to_eth_1,
  dpe_if.master to_eth_2,
  dpe_if.master to_eth_3,
  dpe_if.master to_eth_4
);

  logic [N_PORTS-1:0] in_v;
  logic [N_PORTS-1:0] in_r;
  dpe_beat_t          in_b [N_PORTS];
  logic [N_PORTS-1:0] hd_v;
  dpe_beat_t          hd_b [N_PORTS];

  logic [N_PORTS-1:0] eg_v;
  logic [N_PORTS-1:0] eg_r;
  logic [N_PORTS-1:0] eg_can;
  dpe_beat_t          eg_b [N_PORTS];
  logic [N_PORTS-1:0] ld;
  dpe_beat_t          ld_b [N_PORTS];

  logic [N_PORTS-1:0] act;
  logic [N_PORTS-1:0] gnt;
  logic [N_PORTS-1:0] xfer;
  dpe_mask_t          tgt   [N_PORTS];
  dpe_mask_t          rmask [N_PORTS];
  dpe_mask_t          cmask [N_PORTS];
  dpe_mask_t          olock;
  dpe_mask_t          claimed;
  dpe_addr_t          ptr;
  dpe_addr_t          ptr_n;
  dpe_addr_t          last_g;
  dpe_addr_t          idx;
  logic               any_gnt;

  assign in_v[0] = from_cpu.tvalid;
  assign in_b[0] = {from_cpu.tlast,
    from_cpu.tkeep, from_cpu.tdata,
    from_cpu.tuser_bypass_all,
    from_cpu.tuser_bypass_stage,
    from_cpu.tuser_src, from_cpu.tuser_dst};
  assign from_cpu.tready = in_r[0];

  assign in_v[1] = from_eth_1.tvalid;
  assign in_b[1] = {from_eth_1.tlast,
    from_eth_1.tkeep, from_eth_1.tdata,
    from_eth_1.tuser_bypass_all,
    from_eth_1.tuser_bypass_stage,
    from_eth_1.tuser_src, from_eth_1.tuser_dst};
  assign from_eth_1.tready = in_r[1];

  assign in_v[2] = from_eth_2.tvalid;
  assign in_b[2] = {from_eth_2.tlast,
    from_eth_2.tkeep, from_eth_2.tdata,
    from_eth_2.tuser_bypass_all,
    from_eth_2.tuser_bypass_stage,
    from_eth_2.tuser_src, from_eth_2.tuser_dst};
  assign from_eth_2.tready = in_r[2];

  assign in_v[3] = from_eth_3.tvalid;
  assign in_b[3] = {from_eth_3.tlast,
    from_eth_3.tkeep, from_eth_3.tdata,
    from_eth_3.tuser_bypass_all,
    from_eth_3.tuser_bypass_stage,
    from_eth_3.tuser_src, from_eth_3.tuser_dst};
  assign from_eth_3.tready = in_r[3];

  assign in_v[4] = from_eth_4.tvalid;
  assign in_b[4] = {from_eth_4.tlast,
    from_eth_4.tkeep, from_eth_4.tdata,
    from_eth_4.tuser_bypass_all,
    from_eth_4.tuser_bypass_stage,
    from_eth_4.tuser_src, from_eth_4.tuser_dst};
  assign from_eth_4.tready = in_r[4];

  assign to_cpu.tvalid = eg_v[0];
  assign {to_cpu.tlast,
    to_cpu.tkeep, to_cpu.tdata,
    to_cpu.tuser_bypass_all,
    to_cpu.tuser_bypass_stage,
    to_cpu.tuser_src, to_cpu.tuser_dst} = eg_b[0];
  assign eg_r[0] = to_cpu.tready;

  assign to_eth_1.tvalid = eg_v[1];
  assign {to_eth_1.tlast,
    to_eth_1.tkeep, to_eth_1.tdata,
    to_eth_1.tuser_bypass_all,
    to_eth_1.tuser_bypass_stage,
    to_eth_1.tuser_src, to_eth_1.tuser_dst} = eg_b[1];
  assign eg_r[1] = to_eth_1.tready;

  assign to_eth_2.tvalid = eg_v[2];
  assign {to_eth_2.tlast,
    to_eth_2.tkeep, to_eth_2.tdata,
    to_eth_2.tuser_bypass_all,
    to_eth_2.tuser_bypass_stage,
    to_eth_2.tuser_src, to_eth_2.tuser_dst} = eg_b[2];
  assign eg_r[2] = to_eth_2.tready;

  assign to_eth_3.tvalid = eg_v[3];
  assign {to_eth_3.tlast,
    to_eth_3.tkeep, to_eth_3.tdata,
    to_eth_3.tuser_bypass_all,
    to_eth_3.tuser_bypass_stage,
    to_eth_3.tuser_src, to_eth_3.tuser_dst} = eg_b[3];
  assign eg_r[3] = to_eth_3.tready;

  assign to_eth_4.tvalid = eg_v[4];
  assign {to_eth_4.tlast,
    to_eth_4.tkeep, to_eth_4.tdata,
    to_eth_4.tuser_bypass_all,
    to_eth_4.tuser_bypass_stage,
    to_eth_4.tuser_src, to_eth_4.tuser_dst} = eg_b[4];
  assign eg_r[4] = to_eth_4.tready;

  // Locked inputs keep their latched targets; others route their head.
  for (genvar g = 0; g < N_PORTS; g++) begin : g_in
    dpe_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_v[g]),
      .in_ready  (in_r[g]),
      .in_beat   (in_b[g]),
      .out_valid (hd_v[g]),
      .out_ready (xfer[g]),
      .out_beat  (hd_b[g])
    );
    assign rmask[g] = dpe_route(hd_b[g].dst,
                                dpe_addr_t'(g));
    assign cmask[g] = act[g] ? tgt[g] : rmask[g];
  end

  assign eg_can  = ~eg_v | eg_r;
  assign is_idle = ~|hd_v & ~|act & ~|eg_v;

  always_comb begin
    olock = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (act[i])
        olock = olock | tgt[i];
  end

  // All-or-nothing grant keeps broadcast from deadlocking.
  always_comb begin
    claimed = '0;
    gnt     = '0;
    any_gnt = 1'b0;
    last_g  = ptr;
    idx     = ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = dpe_inc(ptr, k);
      if (!pause && hd_v[idx] && !act[idx] &&
          ((rmask[idx] & (olock | claimed)) == '0)) begin
        gnt[idx] = 1'b1;
        claimed  = claimed | rmask[idx];
        last_g   = idx;
        any_gnt  = 1'b1;
      end
    end
    ptr_n = any_gnt ? dpe_inc(last_g, 1) : ptr;
  end

  always_comb begin
    xfer = '0;
    for (int i = 0; i < N_PORTS; i++)
      xfer[i] = (act[i] | gnt[i]) & hd_v[i] &
                ((cmask[i] & ~eg_can) == '0);
  end

  always_comb begin
    ld = '0;
    for (int o = 0; o < N_PORTS; o++)
      ld_b[o] = '0;
    for (int i = 0; i < N_PORTS; i++)
      for (int o = 0; o < N_PORTS; o++)
        if (xfer[i] && cmask[i][o]) begin
          ld[o]       = 1'b1;
          ld_b[o]     = hd_b[i];
          ld_b[o].src = dpe_addr_t'(i);
        end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      act <= '0;
      for (int i = 0; i < N_PORTS; i++)
        tgt[i] <= '0;
    end else begin
      ptr <= ptr_n;
      for (int i = 0; i < N_PORTS; i++) begin
        if (gnt[i])
          tgt[i] <= rmask[i];
        if (xfer[i] && hd_b[i].last)
          act[i] <= 1'b0;
        else if (gnt[i])
          act[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eg_v <= '0;
      for (int o = 0; o < N_PORTS; o++)
        eg_b[o] <= '0;
    end else begin
      for (int o = 0; o < N_PORTS; o++)
        if (eg_can[o]) begin
          eg_v[o] <= ld[o];
          if (ld[o])
            eg_b[o] <= ld_b[o];
        end
    end
  end

endmodule

// File: tb/tb_dpe.sv
// tb_dpe: directed bench for dpe; unicast, broadcast, backpressure,
// round robin, pause, drop and reset cases.
module tb_dpe;
  import dpe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pause = 1'b0;
  logic is_idle;

  always #5 clk = ~clk;

  dpe_if ii [N_PORTS] (.clk(clk), .rst(rst));
  dpe_if oo [N_PORTS] (.clk(clk), .rst(rst));

  logic [N_PORTS-1:0] iv, il, ir;
  logic [N_PORTS-1:0] ov, ol, ordy, oba, obs;
  logic [DATA_W-1:0]  id [N_PORTS];
  logic [DATA_W-1:0]  od [N_PORTS];
  logic [KEEP_W-1:0]  okeep [N_PORTS];
  dpe_addr_t          idst [N_PORTS];
  dpe_addr_t          osrc [N_PORTS];
  dpe_addr_t          odst [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_io
    assign ii[g].tvalid = iv[g];
    assign ii[g].tlast  = il[g];
    assign ii[g].tkeep  = '1;
    assign ii[g].tdata  = id[g];
    assign ii[g].tuser_bypass_all   = (g % 2) == 1;
    assign ii[g].tuser_bypass_stage = ((g / 2) % 2) == 1;
    assign ii[g].tuser_src = 3'd7;
    assign ii[g].tuser_dst = idst[g];
    assign ir[g]    = ii[g].tready;
    assign ov[g]    = oo[g].tvalid;
    assign ol[g]    = oo[g].tlast;
    assign od[g]    = oo[g].tdata;
    assign okeep[g] = oo[g].tkeep;
    assign oba[g]   = oo[g].tuser_bypass_all;
    assign obs[g]   = oo[g].tuser_bypass_stage;
    assign osrc[g]  = oo[g].tuser_src;
    assign odst[g]  = oo[g].tuser_dst;
    assign oo[g].tready = ordy[g];
  end

  dpe u_dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .is_idle    (is_idle),
    .from_cpu   (ii[0]),
    .from_eth_1 (ii[1]),
    .from_eth_2 (ii[2]),
    .from_eth_3 (ii[3]),
    .from_eth_4 (ii[4]),
    .to_cpu     (oo[0]),
    .to_eth_1   (oo[1]),
    .to_eth_2   (oo[2]),
    .to_eth_3   (oo[3]),
    .to_eth_4   (oo[4])
  );

`ifdef DPE_BCAST_EN
  localparam int BC = 4;
`else
  localparam int BC = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int beats [N_PORTS];
  int got [N_PORTS][8];
  int ord_err, int_err, attr_err;
  int base [8];
  dpe_addr_t dst_of [8];
  dpe_addr_t cur_src [N_PORTS];
  logic [N_PORTS-1:0] in_pkt;
  dpe_addr_t pk1 [$];
  logic clr_req = 1'b0;
  bit stop;
  int ms;
  int pat [6] = '{7, 1, 4, 3, 4, 2};

  function automatic logic [1:0] byp_exp(input int s);
    return {((s / 2) % 2) == 1, (s % 2) == 1};
  endfunction

  // Egress monitor: per port/source beat counts and data order.
  initial forever begin
    @(negedge clk);
    if (clr_req) begin
      for (int o = 0; o < N_PORTS; o++) begin
        beats[o] = 0;
        in_pkt[o] = 1'b0;
        cur_src[o] = '0;
        for (int s = 0; s < 8; s++) got[o][s] = 0;
      end
      ord_err = 0;
      int_err = 0;
      attr_err = 0;
      pk1.delete();
    end else if (rst) begin
      for (int o = 0; o < N_PORTS; o++)
        if (ov[o] && ordy[o]) begin
          ms = int'(osrc[o]);
          if (in_pkt[o] && cur_src[o] != osrc[o]) int_err++;
          if (od[o] !== DATA_W'(base[ms] + got[o][ms])) ord_err++;
          if (okeep[o] !== '1 || odst[o] !== dst_of[ms] ||
              {obs[o], oba[o]} !== byp_exp(ms)) attr_err++;
          got[o][ms]++;
          beats[o]++;
          in_pkt[o] = !ol[o];
          cur_src[o] = osrc[o];
          if (o == 1 && ol[o]) pk1.push_back(osrc[o]);
        end
    end
  end

  task automatic chk(input string tag, input longint obs_v,
                     input longint exp_v);
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    clr_req = 1'b1;
    @(negedge clk);
    step();
    clr_req = 1'b0;
  endtask

  task automatic setup(input int p, input int b, input dpe_addr_t d);
    base[p] = b;
    dst_of[p] = d;
  endtask

  task automatic send(input int p, input int n, input dpe_addr_t d,
                      input int b0);
    int w;
    bit to;
    to = 1'b0;
    for (int k = 0; k < n && !to; k++) begin
      iv[p] = 1'b1;
      il[p] = (k == n - 1);
      id[p] = DATA_W'(b0 + k);
      idst[p] = d;
      w = 0;
      @(negedge clk);
      while (!ir[p] && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (w >= 300) to = 1'b1;
      step();
    end
    iv[p] = 1'b0;
    il[p] = 1'b0;
    chk($sformatf("send%0d_timeout", p), to, 0);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int w;
    w = 0;
    @(negedge clk);
    while (!is_idle && w < max) begin
      @(negedge clk);
      w++;
    end
    chk(tag, is_idle, 1);
    step();
  endtask

  function automatic int total();
    int t;
    t = 0;
    for (int o = 0; o < N_PORTS; o++) t += beats[o];
    return t;
  endfunction

  task automatic setup_mix();
    setup(0, 'h01, 1);
    setup(1, 'h11, 0);
    setup(2, 'h21, 3);
    setup(3, 'h31, 2);
    setup(4, 'h29, 7);
  endtask

  task automatic send_mix();
    fork
      send(0, 6, 1, 'h01);
      send(1, 4, 0, 'h11);
      send(2, 5, 3, 'h21);
      send(3, 4, 2, 'h31);
      send(4, 4, 7, 'h29);
    join
  endtask

  task automatic check_mix(input string t);
    chk({t, "_p0_beats"}, beats[0], 4 + BC);
    chk({t, "_p1_beats"}, beats[1], 6 + BC);
    chk({t, "_p2_beats"}, beats[2], 4 + BC);
    chk({t, "_p3_beats"}, beats[3], 5 + BC);
    chk({t, "_p4_beats"}, beats[4], 0);
    chk({t, "_p1_from0"}, got[1][0], 6);
    chk({t, "_p0_from1"}, got[0][1], 4);
    chk({t, "_p3_from2"}, got[3][2], 5);
    chk({t, "_p2_from3"}, got[2][3], 4);
    chk({t, "_p0_from4"}, got[0][4], BC);
    chk({t, "_order"}, ord_err, 0);
    chk({t, "_interleave"}, int_err, 0);
    chk({t, "_attr"}, attr_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    iv = '0;
    il = '0;
    ordy = '1;
    stop = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      id[p] = '0;
      idst[p] = '0;
    end
    for (int s = 0; s < 8; s++) begin
      base[s] = 0;
      dst_of[s] = '0;
    end

    repeat (2) @(negedge clk);
    chk("rst_tready", ir, 0);
    chk("rst_tvalid", ov, 0);
    chk("rst_tlast", ol, 0);
    chk("rst_idle", is_idle, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    step();
    chk("rel_tready", ir, 5'h1f);
    clear();

    setup_mix();
    send_mix();
    wait_idle("t1_idle", 400);
    check_mix("t1");

    clear();
    stop = 1'b0;
    fork
      begin
        send_mix();
        wait_idle("t2_idle", 800);
        stop = 1'b1;
      end
      begin
        while (!stop)
          for (int j = 0; j < 6 && !stop; j++) begin
            ordy = (j % 2 == 0) ? '1 : '0;
            repeat (pat[j]) step();
          end
      end
    join
    ordy = '1;
    check_mix("t2");

    clear();
    setup(0, 'h40, 1);
    setup(2, 'h60, 1);
    fork
      begin
        send(0, 2, 1, 'h40);
        send(0, 2, 1, 'h42);
      end
      begin
        send(2, 2, 1, 'h60);
        send(2, 2, 1, 'h62);
      end
    join
    wait_idle("rr_idle", 200);
    chk("rr_beats", beats[1], 8);
    chk("rr_pkts", pk1.size(), 4);
    chk("rr_alt01", pk1[0] != pk1[1], 1);
    chk("rr_alt12", pk1[1] != pk1[2], 1);
    chk("rr_alt23", pk1[2] != pk1[3], 1);
    chk("rr_order", ord_err, 0);
    chk("rr_interleave", int_err, 0);

    clear();
    setup(0, 'h70, 1);
    fork
      send(0, 6, 1, 'h70);
      begin
        repeat (3) step();
        pause = 1'b1;
      end
    join
    wait_idle("pz_idle", 200);
    chk("pz_beats", beats[1], 6);
    chk("pz_order", ord_err, 0);
    setup(0, 'h80, 2);
    send(0, 1, 2, 'h80);
    repeat (10) step();
    chk("pz_hold", beats[2], 0);
    chk("pz_busy", is_idle, 0);
    pause = 1'b0;
    wait_idle("pz_rel_idle", 200);
    chk("pz_rel_beats", beats[2], 1);
    chk("pz_rel_order", ord_err, 0);

    clear();
    setup(3, 'h90, 5);
    send(3, 3, 5, 'h90);
    wait_idle("drop5_idle", 200);
    chk("drop5_total", total(), 0);

    clear();
    setup(4, 'hA0, 7);
    send(4, 2, 7, 'hA0);
    wait_idle("bc_idle", 200);
    chk("bc_total", total(), 2 * BC);
    chk("bc_p4", beats[4], 0);
    chk("bc_order", ord_err, 0);

    clear();
    iv[0] = 1'b1;
    il[0] = 1'b0;
    id[0] = DATA_W'('hC0);
    idst[0] = 3'd1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("mr_tvalid", ov, 0);
    chk("mr_idle", is_idle, 1);
    chk("mr_tready", ir, 0);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("mr_rel_tready", ir, 5'h1f);

    clear();
    setup(1, 'hB0, 4);
    send(1, 2, 4, 'hB0);
    wait_idle("post_idle", 200);
    chk("post_beats", beats[4], 2);
    chk("post_order", ord_err, 0);
    chk("post_total", total(), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
